// File: rtl/axis_serdes_pkg.sv
// Shared types and FIFO word layout for the AXI-Stream to FIFO write arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// FIFO word layout, MSB first: {source id, tlast, tdata}.
package axis_serdes_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_t;

  // Bit position of tlast inside a FIFO word.
  function automatic int word_last_bit(input int logic_size);
    return logic_size;
  endfunction

  // LSB of the source-id field inside a FIFO word.
  function automatic int word_id_lsb(input int logic_size);
    return logic_size + 1;
  endfunction

  // Total FIFO word width.
  function automatic int word_width(input int logic_size, input int id_w);
    return logic_size + 1 + id_w;
  endfunction

endpackage

// File: rtl/axis_fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after start, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; pure function of req and start.
//
// Ports:
//   req   - request vector
//   start - index scanned first (must be < N)
//   gnt   - one-hot winner (0 when no request)
//   idx   - binary index of the winner (don't-care when any=0)
//   any   - at least one request present
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;

  always_comb begin
    // Duplicating the vector and shifting right by start puts the request at
    // start in bit 0, so a plain lowest-bit priority encode gives the offset.
    rot = N'({req, req} >> start);
    any = |req;
    off = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = W'(k);
    end
    // Explicit modulo so non-power-of-two N wraps correctly.
    sum = {1'b0, off} + {1'b0, start};
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    idx = sum[W-1:0];
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/axis_fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO write port among NUM_SRC AXI-Stream sources.
// Latency: 1 idle arbitration cycle per packet, then one beat per cycle; FIFO write is combinational with the handshake.
// Backpressure: i_fifo_wfull drops the owner's tready and the write in the same cycle; grant is held until tlast.
//
// Ports:
//   i_clk, i_rst   - FIFO write clock, synchronous active-high reset
//   i_s_tvalid/tdata/tlast, o_s_tready - per-source AXI-Stream slave ports
//   o_fifo_wr, o_fifo_wdata, i_fifo_wfull - FIFO write port, word = {id, last, data}
//   o_grant        - one-hot current owner, 0 when idle
//   o_busy         - a packet is in flight
module axis_fifo_wr_arbiter
  import axis_serdes_pkg::*;
#(
  parameter  int NUM_SRC    = 4,
  parameter  int LOGIC_SIZE = 8,
  localparam int ID_W       = $clog2(NUM_SRC),
  localparam int WORD_W     = word_width(LOGIC_SIZE, ID_W)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_SRC-1:0]                  i_s_tvalid,
  input  logic [NUM_SRC-1:0][LOGIC_SIZE-1:0]  i_s_tdata,
  input  logic [NUM_SRC-1:0]                  i_s_tlast,
  output logic [NUM_SRC-1:0]                  o_s_tready,
  output logic                                o_fifo_wr,
  output logic [WORD_W-1:0]                   o_fifo_wdata,
  input  logic                                i_fifo_wfull,
  output logic [NUM_SRC-1:0]                  o_grant,
  output logic                                o_busy
);

  localparam int LAST_BIT = word_last_bit(LOGIC_SIZE);
  localparam int ID_LSB   = word_id_lsb(LOGIC_SIZE);

  arb_state_t         state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]    owner, owner_nxt;
  logic [NUM_SRC-1:0] grant, grant_nxt;

  logic [NUM_SRC-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  rr_pick #(
    .N (NUM_SRC)
  ) u_rr_pick (
    .req   (i_s_tvalid),
    .start (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      grant  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
      grant  <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    grant_nxt    = grant;
    o_s_tready   = '0;
    o_fifo_wr    = 1'b0;
    o_fifo_wdata = '0;

    // Word is always formed from the registered owner; it is only meaningful
    // when o_fifo_wr is high.
    o_fifo_wdata[LOGIC_SIZE-1:0] = i_s_tdata[owner];
    o_fifo_wdata[LAST_BIT]       = i_s_tlast[owner];
    o_fifo_wdata[ID_LSB +: ID_W] = owner;

    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = STREAM;
          owner_nxt = pick_idx;
          grant_nxt = pick_gnt;
        end
      end
      STREAM: begin
        o_s_tready[owner] = !i_fifo_wfull;
        o_fifo_wr         = i_s_tvalid[owner] && !i_fifo_wfull;
        if (o_fifo_wr && i_s_tlast[owner]) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = (owner == ID_W'(NUM_SRC - 1)) ? '0 : owner + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A reset cycle must not accept or write anything, even mid-packet.
    if (i_rst) begin
      o_s_tready = '0;
      o_fifo_wr  = 1'b0;
    end
  end

  assign o_grant = grant;
  assign o_busy  = (state == STREAM);

endmodule

// File: tb/tb_axis_fifo_wr_arbiter.sv
module tb_axis_fifo_wr_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       s_tvalid = '0;
  logic [3:0][7:0]  s_tdata  = '0;
  logic [3:0]       s_tlast  = '0;
  logic [3:0]       s_tready;
  logic             fifo_wr;
  logic [10:0]      fifo_wdata;
  logic             wfull = 1'b0;
  logic [3:0]       grant;
  logic             busy;

  logic [2:0]       t3_valid = '0;
  logic [2:0][7:0]  t3_data  = '0;
  logic [2:0]       t3_last  = '0;
  logic [2:0]       t3_ready;
  logic             wr3;
  logic [10:0]      wdata3;
  logic             wfull3 = 1'b0;
  logic [2:0]       grant3;
  logic             busy3;

  int checks = 0;
  int errors = 0;

  logic [8:0]  srcq [4][$];
  logic [10:0] exp_q[$];
  logic [3:0]  exp_g[$];
  logic [3:0]  en = 4'hF;
  logic [3:0]  fire = '0;
  logic [3:0]  prev_grant = '0;

  always #5 clk = ~clk;

  axis_fifo_wr_arbiter #(.NUM_SRC(4), .LOGIC_SIZE(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_s_tvalid(s_tvalid), .i_s_tdata(s_tdata), .i_s_tlast(s_tlast),
    .o_s_tready(s_tready),
    .o_fifo_wr(fifo_wr), .o_fifo_wdata(fifo_wdata), .i_fifo_wfull(wfull),
    .o_grant(grant), .o_busy(busy)
  );

  axis_fifo_wr_arbiter #(.NUM_SRC(3), .LOGIC_SIZE(8)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_s_tvalid(t3_valid), .i_s_tdata(t3_data), .i_s_tlast(t3_last),
    .o_s_tready(t3_ready),
    .o_fifo_wr(wr3), .o_fifo_wdata(wdata3), .i_fifo_wfull(wfull3),
    .o_grant(grant3), .o_busy(busy3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue a beat on a source; optionally predict the FIFO word it produces.
  task automatic add_beat(input int src, input logic [7:0] d, input logic last, input logic to_exp);
    logic [1:0] id;
    id = 2'(src);
    srcq[src].push_back({last, d});
    if (to_exp) exp_q.push_back({id, last, d});
  endtask

  task automatic wait_wr(input logic [7:0] d, input int budget);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (fifo_wr && fifo_wdata[7:0] == d) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_wr: data %0h never written within %0d cycles", d, budget);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < budget);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Source model: pops a beat after its handshake, holds it otherwise.
  initial begin
    logic [8:0] h;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (en[i] && srcq[i].size() > 0) begin
          h = srcq[i][0];
          s_tvalid[i] = 1'b1;
          s_tdata[i]  = h[7:0];
          s_tlast[i]  = h[8];
        end else begin
          s_tvalid[i] = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: FIFO words and grant sequence.
  always @(negedge clk) begin
    logic [10:0] e;
    logic [3:0]  g;
    fire = s_tvalid & s_tready;
    if (fifo_wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_extra: got %0h expected no write", fifo_wdata);
      end else begin
        e = exp_q.pop_front();
        if (fifo_wdata !== e) begin
          errors++;
          $display("FAIL word: got %0h expected %0h", fifo_wdata, e);
        end
      end
    end
    if (grant != prev_grant && grant != 4'd0) begin
      checks++;
      if (exp_g.size() == 0) begin
        errors++;
        $display("FAIL grant_extra: got %b expected no new grant", grant);
      end else begin
        g = exp_g.pop_front();
        if (grant !== g) begin
          errors++;
          $display("FAIL grant_order: got %b expected %b", grant, g);
        end
      end
    end
    prev_grant = grant;
  end

  initial begin
    int n;
    // ---------------- reset state
    @(negedge clk);
    chk("rst_grant",  32'(grant),    32'd0);
    chk("rst_busy",   32'(busy),     32'd0);
    chk("rst_wr",     32'(fifo_wr),  32'd0);
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_grant3", 32'(grant3),   32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // ---------------- single source, latency
    @(negedge clk);
    add_beat(0, 8'h11, 1'b0, 1'b1);
    add_beat(0, 8'h22, 1'b0, 1'b1);
    add_beat(0, 8'h33, 1'b1, 1'b1);
    exp_g.push_back(4'b0001);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tvalid[0] && n < 10);
    chk("t1_idle_wr", 32'(fifo_wr), 32'd0);
    for (int off = 1; off <= 4; off++) begin
      @(negedge clk);
      chk("t1_wr_timing", 32'(fifo_wr), 32'(off <= 3));
      chk("t1_busy", 32'(busy), 32'(off <= 3));
    end
    wait_drain("t1_drain", 20);

    // ---------------- all four sources, from reset
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    add_beat(0, 8'h01, 1'b0, 1'b1); add_beat(0, 8'h02, 1'b1, 1'b1);
    add_beat(1, 8'h11, 1'b0, 1'b1); add_beat(1, 8'h12, 1'b1, 1'b1);
    add_beat(2, 8'h21, 1'b0, 1'b1); add_beat(2, 8'h22, 1'b1, 1'b1);
    add_beat(3, 8'h31, 1'b0, 1'b1); add_beat(3, 8'h32, 1'b1, 1'b1);
    add_beat(0, 8'h05, 1'b0, 1'b1); add_beat(0, 8'h06, 1'b1, 1'b1);
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
    exp_g.push_back(4'b0100); exp_g.push_back(4'b1000);
    exp_g.push_back(4'b0001);
    wait_drain("rr_drain", 100);

    // ---------------- backpressure on src1
    add_beat(1, 8'h41, 1'b0, 1'b1); add_beat(1, 8'h42, 1'b0, 1'b1);
    add_beat(1, 8'h43, 1'b0, 1'b1); add_beat(1, 8'h44, 1'b1, 1'b1);
    exp_g.push_back(4'b0010);
    wait_wr(8'h41, 20);
    @(posedge clk); #1 wfull = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_tready", 32'(s_tready[1]), 32'd0);
      chk("bp_wr",     32'(fifo_wr),     32'd0);
      chk("bp_grant",  32'(grant),       32'b0010);
    end
    @(posedge clk); #1 wfull = 1'b0;
    @(negedge clk);
    chk("bp_resume_wr",   32'(fifo_wr),         32'd1);
    chk("bp_resume_data", 32'(fifo_wdata[7:0]), 32'h42);
    wait_drain("bp_drain", 20);

    // ---------------- owner gap with a competing source
    add_beat(2, 8'h51, 1'b0, 1'b1); add_beat(2, 8'h52, 1'b0, 1'b1);
    add_beat(2, 8'h53, 1'b0, 1'b1); add_beat(2, 8'h54, 1'b1, 1'b1);
    exp_g.push_back(4'b0100);
    wait_wr(8'h52, 20);
    en[2] = 1'b0;
    add_beat(0, 8'h61, 1'b0, 1'b1); add_beat(0, 8'h62, 1'b1, 1'b1);
    exp_g.push_back(4'b0001);
    repeat (3) begin
      @(negedge clk);
      chk("gap_grant", 32'(grant),   32'b0100);
      chk("gap_wr",    32'(fifo_wr), 32'd0);
    end
    en[2] = 1'b1;
    wait_drain("gap_drain", 40);

    // ---------------- reset mid-packet
    add_beat(1, 8'h71, 1'b0, 1'b1); add_beat(1, 8'h72, 1'b0, 1'b0);
    add_beat(1, 8'h73, 1'b0, 1'b0); add_beat(1, 8'h74, 1'b1, 1'b0);
    exp_g.push_back(4'b0010);
    wait_wr(8'h71, 20);
    @(posedge clk); #1 rst = 1'b1; en[1] = 1'b0;
    @(negedge clk);
    chk("rstmid_wr",     32'(fifo_wr),  32'd0);
    chk("rstmid_tready", 32'(s_tready), 32'd0);
    @(negedge clk);
    chk("rstmid_grant",  32'(grant),    32'd0);
    chk("rstmid_busy",   32'(busy),     32'd0);
    @(posedge clk); #1 srcq[1].delete(); rst = 1'b0; en[1] = 1'b1;
    @(negedge clk);
    add_beat(3, 8'h81, 1'b1, 1'b1);
    exp_g.push_back(4'b1000);
    wait_drain("rstmid_drain", 20);
    chk("grant_queue_empty", 32'(exp_g.size()), 32'd0);

    // ---------------- NUM_SRC=3: rr_ptr wrap
    @(posedge clk); #1;
    t3_valid = 3'b100; t3_last = 3'b100; t3_data[2] = 8'hC3;
    @(negedge clk);
    chk("n3_arb_idle", 32'(grant3), 32'd0);
    @(negedge clk);
    chk("n3_grant2", 32'(grant3), 32'b100);
    chk("n3_wr",     32'(wr3),    32'd1);
    chk("n3_word",   32'(wdata3), 32'({2'd2, 1'b1, 8'hC3}));
    @(posedge clk); #1;
    t3_valid = 3'b011; t3_last = 3'b011; t3_data[0] = 8'hA0; t3_data[1] = 8'hB1;
    @(negedge clk);
    chk("n3_arb_idle2", 32'(grant3), 32'd0);
    @(negedge clk);
    chk("n3_wrap_grant", 32'(grant3), 32'b001);
    chk("n3_wrap_word",  32'(wdata3), 32'({2'd0, 1'b1, 8'hA0}));
    @(posedge clk); #1 t3_valid = 3'b000;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if something wedges the sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1);
  end

endmodule
